// File: rtl/move_bar.sv
// Paddle controller: moves the bar centre from the push-buttons on a slow
// movement tick, and keeps the current score and the session high score.
module move_bar #(
  parameter int W_BAR    = 64,
  parameter int Y_BAR    = 456,
  parameter int X_INIT   = 320,
  parameter int STEP     = 4,
  parameter int TICK_DIV = 250000,
  parameter int SCORE_W  = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic               hit_bar,
  input  logic               endgame,
  output logic [9:0]         x_bar,
  output logic [9:0]         y_bar,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] high_score,
  output logic [1:0]         estado
);

  localparam int          CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [10:0] MIN_X = 11'(W_BAR);
  localparam logic [10:0] MAX_X = 11'(640 - W_BAR);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   tick_cnt;
  logic               tick;
  logic               hit_prev;
  logic               hit_edge;
  logic [10:0]        x_wide;
  logic [9:0]         x_move;
  logic [SCORE_W-1:0] score_inc;
  logic [SCORE_W-1:0] high_next;

  assign y_bar    = 10'(Y_BAR);
  assign estado   = state;
  assign tick     = (tick_cnt == CNT_W'(TICK_DIV - 1));
  assign hit_edge = hit_bar & ~hit_prev;
  assign x_wide   = {1'b0, x_bar};

  // NOTE: every variable written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    x_move = x_bar;
    if (tick && btn_left && !btn_right) begin
      // Compare before subtracting so a small x_bar can never wrap around.
      if (x_wide >= MIN_X + 11'(STEP)) x_move = x_bar - 10'(STEP);
      else                             x_move = MIN_X[9:0];
    end else if (tick && btn_right && !btn_left) begin
      if (x_wide + 11'(STEP) > MAX_X)  x_move = MAX_X[9:0];
      else                             x_move = x_bar + 10'(STEP);
    end

    score_inc = score;
    if (hit_edge && (score != '1)) score_inc = score + SCORE_W'(1);

    high_next = (score_inc > high_score) ? score_inc : high_score;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      hit_prev   <= 1'b0;
      x_bar      <= 10'(X_INIT);
      score      <= '0;
      high_score <= '0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + CNT_W'(1);
      hit_prev <= hit_bar;

      case (state)
        IDLE: begin
          x_bar <= 10'(X_INIT);
          score <= '0;
          if (start && !endgame) state <= PLAY;
        end

        PLAY: begin
          x_bar <= x_move;
          score <= score_inc;
          // Any exit from PLAY folds this cycle's score into the high score.
          if (endgame) begin
            state      <= OVER;
            high_score <= high_next;
          end else if (!start) begin
            state      <= IDLE;
            high_score <= high_next;
          end
        end

        OVER: begin
          if (!start) begin
            state <= IDLE;
            x_bar <= 10'(X_INIT);
            score <= '0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_move_bar.sv
// Directed bench for move_bar: a table of held input patterns with expected
// outputs, plus hand sequences for tick cadence, saturation and reset.
module tb_move_bar;

  localparam int TICK_DIV = 4;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_OVER = 2'd2;

  logic       clock = 1'b0;
  logic       reset, start, btn_left, btn_right, hit_bar, endgame;
  logic [9:0] x_bar, y_bar;
  logic [7:0] score, high_score;
  logic [1:0] estado;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       s, l, r, h, e;
    int         n;
    int         x, sc, hs;
    logic [1:0] st;
  } vec_t;

  vec_t vecs[$];

  move_bar #(.TICK_DIV(TICK_DIV)) dut (
    .clock(clock), .reset(reset), .start(start),
    .btn_left(btn_left), .btn_right(btn_right),
    .hit_bar(hit_bar), .endgame(endgame),
    .x_bar(x_bar), .y_bar(y_bar), .score(score),
    .high_score(high_score), .estado(estado)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, l, r, h, e);
    start = s; btn_left = l; btn_right = r; hit_bar = h; endgame = e;
  endtask

  // Outputs are sampled 1 ns after the edge that updates them.
  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check_all(input string tag, input int x, sc, hs, input logic [1:0] st);
    check({tag, " x_bar"}, 32'(x_bar), 32'(x));
    check({tag, " score"}, 32'(score), 32'(sc));
    check({tag, " high_score"}, 32'(high_score), 32'(hs));
    check({tag, " estado"}, 32'(estado), 32'(st));
  endtask

  function automatic vec_t v(input logic s, l, r, h, e, input int n,
                             input int x, sc, hs, input logic [1:0] st);
    vec_t t;
    t.s = s; t.l = l; t.r = r; t.h = h; t.e = e; t.n = n;
    t.x = x; t.sc = sc; t.hs = hs; t.st = st;
    return t;
  endfunction

  initial begin
    int changes;
    logic [9:0] prev_x;

    //                s  l  r  h  e   n    x   sc hs  state
    vecs.push_back(v(0, 0, 0, 0, 0,   1, 320, 0, 0, S_IDLE));
    vecs.push_back(v(1, 0, 0, 0, 0,   1, 320, 0, 0, S_PLAY));
    vecs.push_back(v(1, 0, 1, 0, 0,  40, 360, 0, 0, S_PLAY));  // 10 ticks right
    vecs.push_back(v(1, 1, 1, 0, 0,  12, 360, 0, 0, S_PLAY));  // both: no move
    vecs.push_back(v(1, 1, 0, 0, 0,   4, 356, 0, 0, S_PLAY));  // one tick left
    vecs.push_back(v(1, 1, 0, 0, 0, 400,  64, 0, 0, S_PLAY));  // left clamp
    vecs.push_back(v(1, 0, 1, 0, 0, 800, 576, 0, 0, S_PLAY));  // right clamp
    vecs.push_back(v(1, 0, 0, 1, 0,  20, 576, 1, 0, S_PLAY));  // long hit once
    vecs.push_back(v(1, 0, 0, 0, 0,   5, 576, 1, 0, S_PLAY));
    vecs.push_back(v(1, 0, 0, 1, 0,   3, 576, 2, 0, S_PLAY));
    vecs.push_back(v(1, 0, 0, 0, 0,   1, 576, 2, 0, S_PLAY));
    vecs.push_back(v(1, 0, 0, 1, 0,   1, 576, 3, 0, S_PLAY));
    vecs.push_back(v(1, 0, 0, 0, 0,   1, 576, 3, 0, S_PLAY));
    vecs.push_back(v(1, 0, 0, 1, 0,   1, 576, 4, 0, S_PLAY));
    vecs.push_back(v(1, 0, 0, 0, 0,   1, 576, 4, 0, S_PLAY));
    vecs.push_back(v(1, 0, 0, 1, 0,   1, 576, 5, 0, S_PLAY));
    vecs.push_back(v(1, 0, 0, 0, 0,   1, 576, 5, 0, S_PLAY));
    vecs.push_back(v(1, 0, 0, 1, 1,   1, 576, 6, 6, S_OVER));  // hit in exit cycle
    vecs.push_back(v(1, 1, 0, 0, 0,   8, 576, 6, 6, S_OVER));  // buttons ignored
    vecs.push_back(v(1, 0, 0, 1, 0,   1, 576, 6, 6, S_OVER));  // hit ignored
    vecs.push_back(v(0, 0, 0, 0, 0,   1, 320, 0, 6, S_IDLE));
    vecs.push_back(v(1, 0, 0, 0, 0,   1, 320, 0, 6, S_PLAY));
    vecs.push_back(v(1, 0, 0, 1, 0,   1, 320, 1, 6, S_PLAY));
    vecs.push_back(v(1, 0, 0, 0, 0,   1, 320, 1, 6, S_PLAY));
    vecs.push_back(v(1, 0, 0, 1, 0,   1, 320, 2, 6, S_PLAY));
    vecs.push_back(v(1, 0, 0, 0, 0,   1, 320, 2, 6, S_PLAY));
    vecs.push_back(v(1, 0, 0, 1, 0,   1, 320, 3, 6, S_PLAY));
    vecs.push_back(v(1, 0, 0, 0, 1,   1, 320, 3, 6, S_OVER));  // lower score
    vecs.push_back(v(0, 0, 0, 0, 0,   1, 320, 0, 6, S_IDLE));
    vecs.push_back(v(1, 0, 0, 0, 1,   2, 320, 0, 6, S_IDLE));  // endgame blocks start
    vecs.push_back(v(1, 0, 0, 0, 0,   1, 320, 0, 6, S_PLAY));
    vecs.push_back(v(1, 0, 0, 1, 0,   1, 320, 1, 6, S_PLAY));
    vecs.push_back(v(0, 0, 0, 0, 0,   2, 320, 0, 6, S_IDLE));  // aborted game

    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    cycles(2);
    check("reset y_bar", 32'(y_bar), 32'd456);
    check_all("reset", 320, 0, 0, S_IDLE);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].s, vecs[i].l, vecs[i].r, vecs[i].h, vecs[i].e);
      cycles(vecs[i].n);
      check_all($sformatf("row%0d", i), vecs[i].x, vecs[i].sc, vecs[i].hs, vecs[i].st);
    end

    // Movement cadence: two ticks in eight cycles, each one a single step.
    drive(1, 0, 0, 0, 0);
    cycles(1);
    drive(1, 0, 1, 0, 0);
    changes = 0;
    prev_x  = x_bar;
    for (int i = 0; i < 8; i++) begin
      cycles(1);
      if (x_bar != prev_x) begin
        changes++;
        check("cadence step", 32'(x_bar), 32'(prev_x) + 32'd4);
      end
      prev_x = x_bar;
    end
    check("cadence changes", 32'(changes), 32'd2);
    check("cadence x_bar", 32'(x_bar), 32'd328);
    drive(0, 0, 0, 0, 0);
    cycles(2);
    check_all("after abort", 320, 0, 6, S_IDLE);

    // Score saturation at 255, then high score takes it on game over.
    drive(1, 0, 0, 0, 0);
    cycles(1);
    for (int i = 0; i < 260; i++) begin
      drive(1, 0, 0, 1, 0); cycles(1);
      drive(1, 0, 0, 0, 0); cycles(1);
    end
    check_all("saturate", 320, 255, 6, S_PLAY);
    drive(1, 0, 0, 1, 1);
    cycles(1);
    check_all("sat over", 320, 255, 255, S_OVER);
    drive(0, 0, 0, 0, 0);
    cycles(1);
    check_all("sat idle", 320, 0, 255, S_IDLE);

    // Reset in mid-game dominates start, buttons and hit.
    drive(1, 0, 0, 0, 0);
    cycles(1);
    drive(1, 0, 1, 0, 0);
    cycles(8);
    check("pre-reset x_bar", 32'(x_bar), 32'd328);
    reset = 1'b1;
    drive(1, 1, 0, 1, 0);
    cycles(1);
    check_all("mid reset", 320, 0, 0, S_IDLE);
    reset = 1'b0;
    drive(0, 0, 0, 0, 0);
    cycles(1);
    check_all("post reset", 320, 0, 0, S_IDLE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/move_bar.md
Name: move_bar

Overview:
- Paddle controller: the counterpart to the ball mover.
- Produces the bar centre (x_bar, y_bar) that the ball mover consumes.
- Consumes the ball mover's hit_bar and endgame outputs to keep the current score and a session high score.
- Sits between the board push-buttons and the ball mover; its outputs also drive the VGA renderer and the LEDs/7-seg.

Parameters:
- W_BAR, 64, half bar width in pixels.
- Y_BAR, 456, fixed bar centre row.
- X_INIT, 320, bar centre column after reset and on each new game.
- STEP, 4, pixels moved per movement tick.
- TICK_DIV, 250000, clock cycles per movement tick (100 Hz at 25 MHz).
- SCORE_W, 8, score / high-score width.

Ports:
- clock, input, 1, system clock.
- reset, input, 1, synchronous active-high reset.
- start, input, 1, game-enable switch (level).
- btn_left, input, 1, move-left button (active-high, already synchronised).
- btn_right, input, 1, move-right button (active-high, already synchronised).
- hit_bar, input, 1, ball touching bar (level, from ball mover).
- endgame, input, 1, ball reached bottom (from ball mover).
- x_bar, output, 10, bar centre column.
- y_bar, output, 10, bar centre row; constant Y_BAR.
- score, output, SCORE_W, bar hits in the current game.
- high_score, output, SCORE_W, best score since reset.
- estado, output, 2, FSM state for LEDs: 0 IDLE, 1 PLAY, 2 OVER.

Behaviour:
- One clock. Reset is synchronous and active-high; reset dominates every other input.
- Reset values:
  - x_bar=X_INIT, score=0, high_score=0, estado=IDLE.
  - Tick counter=0, hit_bar history register=0.
- Tick counter:
  - Free-running 0..TICK_DIV-1, wraps to 0.
  - Internal tick is high for exactly one cycle, when the count equals TICK_DIV-1.
  - Runs in all states.
- Hit edge: hit_edge = hit_bar & ~hit_prev, where hit_prev is hit_bar registered every cycle.
- IDLE:
  - x_bar forced to X_INIT and score forced to 0; buttons ignored.
  - start=1 & endgame=0 -> PLAY next cycle.
  - start=1 & endgame=1 -> stay IDLE.
- PLAY: movement is evaluated only on tick cycles.
  - btn_left only: x_bar = max(x_bar-STEP, W_BAR).
  - btn_right only: x_bar = min(x_bar+STEP, 640-W_BAR).
  - Both or neither pressed: no move.
  - Clamp comparisons use 11-bit arithmetic so the left subtraction never underflows.
  - On hit_edge, score increments by 1, saturating at 2^SCORE_W-1. A hit held for many cycles counts once.
  - endgame=1 -> OVER.
  - start=0 (and endgame=0) -> IDLE (game aborted).
- High-score update:
  - Applies on any PLAY exit, in the exit cycle.
  - high_score <= max(high_score, score_next), where score_next includes a hit_edge occurring in that same cycle.
- OVER:
  - x_bar and score held; buttons and hit_edge ignored.
  - start=0 -> IDLE, which clears score and recentres x_bar on that transition.
  - start held high -> stay OVER, even after endgame drops.
- Latency: every output is registered and updates one cycle after its cause. A tick plus button press in cycle n gives the new x_bar visible at n+1.
- high_score is changed only by reset and by the PLAY-exit update.

Test Plan (TICK_DIV=4 in sim):
- Reset, start=1 one cycle later -> estado IDLE then PLAY; x_bar=320, y_bar=456, score=0.
- PLAY, btn_right held 10 ticks -> x_bar=360. Then both buttons held 3 ticks -> x_bar stays 360.
- btn_left held 100 ticks from 320 -> x_bar steps down by 4 per tick, stops at 64 and never wraps. btn_right held 200 ticks -> stops at 576.
- hit_bar high for 20 cycles, low 5 cycles, high 3 cycles -> score=2.
- Score 255, further hit edge -> score stays 255.
- score=5, then endgame=1 together with a hit edge -> estado OVER, score=6, high_score=6.
  - start=0 -> IDLE, score=0, x_bar=320, high_score=6.
  - Next game ends with score 3 -> high_score stays 6.
  - reset -> high_score=0.
